// File: rtl/calc_div_sequencer_pkg.sv
// Shared encodings for the calculator divide sequencer and the keypad controller.
package calc_div_sequencer_pkg;

    // Divide sequencer FSM states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // ALU opcode the keypad controller associates with the subtract step
    localparam logic [2:0] ALU_SUB = 3'h3;

    // Keypad code of the F (divide) key
    localparam logic [3:0] KEY_F = 4'hF;

endpackage

// File: rtl/calc_div_step.sv
// One restoring shift-subtract division iteration, purely combinational.
module calc_div_step
    import calc_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] diff;
    // The partial remainder always stays below the divisor, so its top bit
    // is never needed for the shift.
    logic           unused_r_msb;

    assign unused_r_msb = r[WIDTH];

    // Shift in the next dividend bit and keep the difference if it did not borrow.
    always_comb begin
        r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
        diff    = r_shift - {1'b0, d};
        if (!diff[WIDTH]) begin
            r_next = diff;
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift;
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/calc_div_sequencer.sv
// Multi-cycle unsigned divider for the calculator F key.
//
//   state    | meaning
//   DIV_IDLE | waiting for start
//   DIV_RUN  | one quotient bit per enabled cycle
//   DIV_DONE | results just updated, done pulse
module calc_div_sequencer
    import calc_div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    calc_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (step_r),
        .q_next (step_q)
    );

    // State, working and result registers; everything holds while enable is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                // cancel has no meaning outside RUN, so a start here always wins
                if (start) begin
                    if (divisor != '0) begin
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = DIV_RUN;
                    end else begin
                        quot_d  = '0;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DIV_DONE;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    r_d = step_r;
                    q_d = step_q;
                    if (cnt_q == '0) begin
                        quot_d  = step_q;
                        rem_d   = step_r[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == DIV_RUN);
    assign done        = (state_q == DIV_DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;

endmodule

// File: doc/calc_div_sequencer.md
Name: calc_div_sequencer

Overview:
- Multi-cycle controller that performs unsigned integer division for the calculator's F (divide) key, which currently has no sequencing logic.
- Runs a restoring shift-subtract loop, one quotient bit per cycle.
- Sits beside the keypad state machine: that machine pulses start with previous/current operands and consumes quotient on done.
- Owns its working registers, iteration counter and start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥2)
- CNT_W, $clog2(WIDTH), iteration counter width

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  clock enable; when low, all registers hold
- start  input  1  request a division; sampled only when enable=1
- cancel  input  1  abort a running division
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse: results just updated
- div_by_zero  output  1  last accepted operation had divisor==0
- quotient  output  WIDTH  result register
- remainder  output  WIDTH  result register

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high, and overrides enable, start and cancel.
- Reset values:
  - state=IDLE
  - busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0
  - working registers=0, counter=0
- enable=0: no state, counter, working or result register changes. A done pulse stretches for as long as enable stays low.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with divisor≠0: capture operands. Working remainder R (WIDTH+1 bits)=0, working quotient Q=dividend, D=divisor, counter=WIDTH-1. Go to RUN.
  - start=1 with divisor=0: go to DONE. Load quotient=0, remainder=dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- RUN (busy=1), one iteration per enabled edge:
  - R'={R[WIDTH-1:0],Q[WIDTH-1]}
  - T=R'-{1'b0,D}, computed at WIDTH+1 bits
  - T[WIDTH]=0: R=T, Q={Q[WIDTH-2:0],1}
  - otherwise: R=R', Q={Q[WIDTH-2:0],0}
  - counter>0: decrement counter.
  - counter=0: load quotient=next Q, remainder=next R[WIDTH-1:0], div_by_zero=0, then go to DONE.
- DONE (done=1, busy=0):
  - start=1: accepted exactly as in IDLE (back-to-back operation allowed).
  - otherwise: go to IDLE.
- Latency:
  - start accepted on edge E0; iterations occupy edges E1..E_WIDTH.
  - done is high in the cycle after E_WIDTH (WIDTH enabled cycles after acceptance).
  - Divide-by-zero: done is high in the cycle after E0.
- Handshake rules:
  - start is ignored in RUN.
  - Operands matter only on the accepting edge and may change afterwards.
- cancel:
  - In RUN, the next enabled edge goes to IDLE. No done pulse; quotient, remainder and div_by_zero keep their prior values.
  - cancel together with start in RUN: cancel wins, start is dropped.
  - cancel in IDLE or DONE is ignored; start in the same cycle is still accepted.
- Result registers change only on completion or divide-by-zero, so the display never shows partial values.
- Width rules: all arithmetic is unsigned. The subtraction uses an extra bit for the borrow; no overflow is possible.

Decomposition:
- Shared package/include:
  - state encodings DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2
  - ALU opcode ALU_SUB (3'h3) and the key code for F, so the keypad controller and this block agree
- One natural sub-module: calc_div_step, a combinational single iteration. Inputs R, Q, D; outputs next R and next Q. The top level holds the FSM, counter and registers.

Test Plan:
- Nominal case, WIDTH=32, enable=1: start with 100/7 → busy for 32 cycles, then done pulse; quotient=14, remainder=2, div_by_zero=0; then IDLE.
- Divide by zero: start with 5/0 → done in the cycle after start, busy never high; quotient=0, remainder=5, div_by_zero=1. Next run 9/3 → quotient=3, remainder=0, div_by_zero=0.
- Extreme values:
  - 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
  - 3/10 → quotient=0, remainder=3.
  - 0xFFFFFFFF/0xFFFFFFFF → quotient=1, remainder=0.
- Cancel and restart: complete 100/7, then start 50/4 and assert cancel on the 10th RUN cycle → IDLE next cycle, no done, outputs still 14/2. Start during the final done pulse is accepted and yields 12/2.
- Enable stall: start 1000/33 and drop enable for 5 cycles mid-run → done arrives exactly 5 cycles later than nominal; quotient=30, remainder=10.
- Reset and busy-start: reset mid-run → next cycle IDLE, all outputs 0. Start held high through an entire run → only one operation, re-accepted in the DONE state.
